mem_sram_bank: RTL and testbench

Parametrised single-port SRAM bank; successor to the fixed 32 kB, 256-bit bank. Width, depth and bank-ID width are configurable. Adds a ready/valid-style request/response handshake, 1- or 2-cycle read latency, and an internal read-modify-write path for masked writes when the macro has no bit-write enable. Instances sit behind the memory interconnect, one per bank, selected by the upper address bits.

---
 rtl/mem_sram_pkg.sv | 24 ++
 rtl/mem_sram_array.sv | 33 +++
 rtl/mem_sram_bank.sv | 194 +++++++++++++++++++
 tb/tb_mem_sram_bank.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sram_pkg.sv
// Shared types and helpers for the mem_sram bank slice.
// Statistics counters are enabled by MEM_SRAM_BANK_STATS_EN.
package mem_sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RMW_RD,
    RMW_WR
  } rmw_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RW_BOTH = 2'd1;
  localparam logic [1:0] ERR_NO_OP   = 2'd2;
  localparam logic [1:0] ERR_BANK    = 2'd3;

  function automatic int addr_w(
    input int data_w,
    input int depth,
    input int id_w
  );
    return id_w + $clog2(depth) + $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_sram_array.sv
// Raw single-port storage, synchronous read, bit-masked write.
// Swap point for a foundry macro; contents are never reset.
module mem_sram_array #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 1024,
  parameter int ROW_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] bmask_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[row_i] <= (wdata_i & bmask_i)
                      | (mem_q[row_i] & ~bmask_i);
      end else begin
        rdata_q <= mem_q[row_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_sram_bank.sv
// Parametrised SRAM bank: handshake, RMW FSM, read pipeline, errors.
// Optional saturating counters under MEM_SRAM_BANK_STATS_EN.
module mem_sram_bank
  import mem_sram_pkg::*;
#(
  parameter int DATA_W   = 256,
  parameter int DEPTH    = 1024,
  parameter int ID_W     = 4,
  parameter int READ_LAT = 1,
  parameter int BIT_WE   = 1,
  localparam int OFF_W   = $clog2(DATA_W / 8),
  localparam int ROW_W   = $clog2(DEPTH),
  localparam int ADDR_W  = addr_w(DATA_W, DEPTH, ID_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [ID_W-1:0]   id,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mask_enable,
  input  logic [DATA_W-1:0] mask,
  output logic              ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              err
`ifdef MEM_SRAM_BANK_STATS_EN
  ,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  output logic [31:0]       err_cnt
`endif
);

  rmw_state_e        state_q;
  logic [ROW_W-1:0]  row_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] mk_q;
  logic [DATA_W-1:0] merged_q;
  logic              err_q;
  logic              rv1_q;

  logic [ROW_W-1:0]  row;
  logic [ID_W-1:0]   bank;
  logic [1:0]        reason;
  logic              acc, ok;
  logic              acc_rd, acc_wr, acc_err;
  logic              rmw_go;

  logic              a_en, a_we;
  logic [ROW_W-1:0]  a_row;
  logic [DATA_W-1:0] a_wdata, a_bmask, a_rdata;

  assign row  = addr[OFF_W+ROW_W-1:OFF_W];
  assign bank = addr[ADDR_W-1:OFF_W+ROW_W];

  assign ready = (state_q == IDLE) && !rst;
  assign acc   = cs && ready;

  always_comb begin
    reason = ERR_NONE;
    unique case (1'b1)
      read && write:                   reason = ERR_RW_BOTH;
      !read && !write:                 reason = ERR_NO_OP;
      (read ^ write) && (bank != id):  reason = ERR_BANK;
      (read ^ write) && (bank == id):  reason = ERR_NONE;
    endcase
  end

  assign ok      = (reason == ERR_NONE);
  assign acc_rd  = acc && ok && read;
  assign acc_wr  = acc && ok && write;
  assign acc_err = acc && !ok;
  assign rmw_go  = acc_wr && mask_enable && (BIT_WE == 0);

  // RMW write-back owns the port; a new request can never coincide with it
  always_comb begin
    a_en    = 1'b0;
    a_we    = 1'b0;
    a_row   = row;
    a_wdata = data_in;
    a_bmask = '1;
    if (rst) begin
      a_en = 1'b0;
    end else if (state_q == RMW_WR) begin
      a_en    = 1'b1;
      a_we    = 1'b1;
      a_row   = row_q;
      a_wdata = merged_q;
    end else if (acc_rd || rmw_go) begin
      a_en = 1'b1;
    end else if (acc_wr) begin
      a_en    = 1'b1;
      a_we    = 1'b1;
      a_bmask = mask_enable ? mask : '1;
    end
  end

  mem_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ROW_W  (ROW_W)
  ) u_array (
    .clk     (clk),
    .en_i    (a_en),
    .we_i    (a_we),
    .row_i   (a_row),
    .wdata_i (a_wdata),
    .bmask_i (a_bmask),
    .rdata_o (a_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      err_q <= acc_err;
      rv1_q <= acc_rd;
      unique case (state_q)
        IDLE: begin
          if (rmw_go) begin
            state_q <= RMW_RD;
            row_q   <= row;
            wd_q    <= data_in;
            mk_q    <= mask;
          end
        end
        RMW_RD: begin
          merged_q <= (wd_q & mk_q) | (a_rdata & ~mk_q);
          state_q  <= RMW_WR;
        end
        RMW_WR:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign err = err_q;

  logic [DATA_W-1:0] dout_q;

  generate
    if (READ_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) dout_q <= '0;
        else if (rv1_q) dout_q <= a_rdata;
      end
      assign rd_valid = rv1_q;
      assign data_out = rv1_q ? a_rdata : dout_q;
    end else begin : g_lat2
      logic rv2_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rv2_q  <= 1'b0;
          dout_q <= '0;
        end else begin
          rv2_q <= rv1_q;
          if (rv1_q) dout_q <= a_rdata;
        end
      end
      assign rd_valid = rv2_q;
      assign data_out = dout_q;
    end
  endgenerate

`ifdef MEM_SRAM_BANK_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (acc_rd)  rd_cnt_q  <= sat_inc(rd_cnt_q);
      if (acc_wr)  wr_cnt_q  <= sat_inc(wr_cnt_q);
      if (acc_err) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_sram_bank.sv
// Scoreboard bench: two banks (lat1/RMW and lat2/bit-write) share stimulus.
// Stats checks are compiled in with MEM_SRAM_BANK_STATS_EN.
module tb_mem_sram_bank;

  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic [3:0]    id;
  logic          read, write;
  logic [9:0]    addr;
  logic [DW-1:0] data_in;
  logic          mask_enable;
  logic [DW-1:0] mask;

  logic          ready_a, rd_valid_a, err_a;
  logic [DW-1:0] data_out_a;
  logic          ready_b, rd_valid_b, err_b;
  logic [DW-1:0] data_out_b;
`ifdef MEM_SRAM_BANK_STATS_EN
  logic [31:0]   rd_cnt_a, wr_cnt_a, err_cnt_a;
  logic [31:0]   rd_cnt_b, wr_cnt_b, err_cnt_b;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t qa[$];
  exp_t qb[$];
  int   qea[$];
  int   qeb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_sram_bank #(
    .DATA_W(DW), .DEPTH(16), .ID_W(4), .READ_LAT(1), .BIT_WE(0)
  ) dut_a (
    .clk(clk), .rst(rst), .cs(cs), .id(id), .read(read),
    .write(write), .addr(addr), .data_in(data_in),
    .mask_enable(mask_enable), .mask(mask), .ready(ready_a),
    .rd_valid(rd_valid_a), .data_out(data_out_a), .err(err_a)
`ifdef MEM_SRAM_BANK_STATS_EN
    , .rd_cnt(rd_cnt_a), .wr_cnt(wr_cnt_a), .err_cnt(err_cnt_a)
`endif
  );

  mem_sram_bank #(
    .DATA_W(DW), .DEPTH(16), .ID_W(4), .READ_LAT(2), .BIT_WE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .cs(cs), .id(id), .read(read),
    .write(write), .addr(addr), .data_in(data_in),
    .mask_enable(mask_enable), .mask(mask), .ready(ready_b),
    .rd_valid(rd_valid_b), .data_out(data_out_b), .err(err_b)
`ifdef MEM_SRAM_BANK_STATS_EN
    , .rd_cnt(rd_cnt_b), .wr_cnt(wr_cnt_b), .err_cnt(err_cnt_b)
`endif
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic req(
    input logic r, input logic w,
    input logic [3:0] b, input logic [3:0] row,
    input logic [DW-1:0] d, input logic me, input logic [DW-1:0] m,
    input logic ea_v, input logic [DW-1:0] ea,
    input logic eb_v, input logic [DW-1:0] eb,
    input logic er
  );
    int n = 0;
    int k;
    while (!(ready_a && ready_b) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, ready_a && ready_b}, 32'd1);
    cs = 1'b1;
    read = r;
    write = w;
    addr = {b, row, 2'b00};
    data_in = d;
    mask_enable = me;
    mask = m;
    k = cyc;
    if (ea_v) qa.push_back('{d: ea, c: k + 1});
    if (eb_v) qb.push_back('{d: eb, c: k + 2});
    if (er) begin
      qea.push_back(k + 1);
      qeb.push_back(k + 1);
    end
    @(negedge clk);
    cs = 1'b0;
    read = 1'b0;
    write = 1'b0;
    mask_enable = 1'b0;
  endtask

  task automatic wr(input logic [3:0] row, input logic [DW-1:0] d);
    req(0, 1, 4'd2, row, d, 0, '0, 0, '0, 0, '0, 0);
  endtask

  task automatic rd(input logic [3:0] row, input logic [DW-1:0] ea,
                    input logic [DW-1:0] eb);
    req(1, 0, 4'd2, row, '0, 0, '0, 1, ea, 1, eb, 0);
  endtask

  task automatic bad(input logic r, input logic w, input logic [3:0] b);
    req(r, w, b, 4'd3, '0, 0, '0, 0, '0, 0, '0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int c;
    if (rd_valid_a) begin
      if (qa.size() == 0) chk("a_unexpected_rd_valid", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_rd_data", data_out_a, e.d);
        chk("a_rd_cycle", cyc, e.c);
      end
    end
    if (rd_valid_b) begin
      if (qb.size() == 0) chk("b_unexpected_rd_valid", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_rd_data", data_out_b, e.d);
        chk("b_rd_cycle", cyc, e.c);
      end
    end
    if (err_a) begin
      if (qea.size() == 0) chk("a_unexpected_err", 32'd1, 32'd0);
      else begin
        c = qea.pop_front();
        chk("a_err_cycle", cyc, c);
      end
    end
    if (err_b) begin
      if (qeb.size() == 0) chk("b_unexpected_err", 32'd1, 32'd0);
      else begin
        c = qeb.pop_front();
        chk("b_err_cycle", cyc, c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cs = 1'b0;
    id = 4'd2;
    read = 1'b0;
    write = 1'b0;
    addr = '0;
    data_in = '0;
    mask_enable = 1'b0;
    mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready_a", {31'd0, ready_a}, 32'd0);
    chk("rst_ready_b", {31'd0, ready_b}, 32'd0);
    chk("rst_rd_valid", {30'd0, rd_valid_a, rd_valid_b}, 32'd0);
    chk("rst_err", {30'd0, err_a, err_b}, 32'd0);
    chk("rst_dout_a", data_out_a, 32'd0);
    chk("rst_dout_b", data_out_b, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {30'd0, ready_a, ready_b}, 32'd3);

    wr(4'd3, 32'hA5A5_A5A5);
    rd(4'd3, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    // masked write: dut_a goes through RMW, dut_b writes natively
    wr(4'd5, 32'hFFFF_FFFF);
    req(0, 1, 4'd2, 4'd5, 32'h0, 1, 32'h0000_00FF, 0, '0, 0, '0, 0);
    chk("rmw_ready_a_t1", {31'd0, ready_a}, 32'd0);
    chk("rmw_ready_b_t1", {31'd0, ready_b}, 32'd1);
    @(negedge clk);
    chk("rmw_ready_a_t2", {31'd0, ready_a}, 32'd0);
    @(negedge clk);
    chk("rmw_ready_a_t3", {31'd0, ready_a}, 32'd1);
    rd(4'd5, 32'hFFFF_FF00, 32'hFFFF_FF00);

    bad(1, 1, 4'd2);
    bad(1, 0, 4'd7);
    bad(0, 1, 4'd7);
    bad(0, 0, 4'd2);
    rd(4'd3, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    for (int i = 0; i < 4; i++)
      wr(4'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 4; i++)
      rd(4'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101,
         32'h1000_0000 + 32'(i) * 32'h0101_0101);
    repeat (4) @(negedge clk);
    chk("hold_dout_a", data_out_a, 32'h1303_0303);
    chk("hold_dout_b", data_out_b, 32'h1303_0303);

`ifdef MEM_SRAM_BANK_STATS_EN
    chk("rd_cnt_a", rd_cnt_a, 32'd7);
    chk("wr_cnt_a", wr_cnt_a, 32'd7);
    chk("err_cnt_a", err_cnt_a, 32'd4);
    chk("err_cnt_b", err_cnt_b, 32'd4);
    force dut_a.rd_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut_a.rd_cnt_q;
    for (int i = 0; i < 3; i++)
      rd(4'd0, 32'h1000_0000, 32'h1000_0000);
    repeat (3) @(negedge clk);
    chk("rd_cnt_sat", rd_cnt_a, 32'hFFFF_FFFF);
`endif

    // reset flushes dut_b's in-flight read; dut_a's already emerged
    wr(4'd6, 32'h1111_1111);
    req(1, 0, 4'd2, 4'd6, '0, 0, '0, 1, 32'h1111_1111, 0, '0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("flush_ready", {30'd0, ready_a, ready_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("flush_ready_back", {30'd0, ready_a, ready_b}, 32'd3);

    // reset while dut_a sits in RMW_RD drops the pending write
    req(0, 1, 4'd2, 4'd6, 32'h0, 1, 32'h0000_00FF, 0, '0, 0, '0, 0);
    chk("rmw_rst_ready_a", {31'd0, ready_a}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rmw_rst_ready_back", {30'd0, ready_a, ready_b}, 32'd3);
    rd(4'd6, 32'h1111_1111, 32'h1111_1100);

    repeat (5) @(negedge clk);
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    chk("qerr_drained", qea.size() + qeb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
